// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus a single-outstanding instruction fetch sequencer.
// Presents {instr, pc, valid} to IF/ID and discards responses made stale by a redirect.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inPCPlus4,
    output logic [31:0] outPC,
    input  logic        inException,
    input  logic        inBranchTaken,
    input  logic [31:0] inBranchTarget,
    input  logic        inJump,
    input  logic [31:0] inJumpTarget,
    input  logic        inStall,
    output logic        outImemReq,
    output logic [31:0] outImemAddr,
    input  logic        inImemAck,
    input  logic [31:0] inImemData,
    output logic [31:0] outInstr,
    output logic [31:0] outInstrPC,
    output logic        outInstrValid,
    output logic        outFetchFault,
    output logic [31:0] outFaultAddr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] req_addr, req_addr_next;
    logic        squash, squash_next;
    logic [31:0] instr, instr_next;
    logic [31:0] instr_pc, instr_pc_next;
    logic        instr_valid, instr_valid_next;
    logic [31:0] buf_data, buf_data_next;
    logic [31:0] buf_pc, buf_pc_next;
    logic        fetch_fault, fetch_fault_next;
    logic [31:0] fault_addr, fault_addr_next;

    logic        redirect;
    logic        misaligned;
    logic [31:0] raw_target;
    logic [31:0] redirect_pc;
    logic        slot_free;
    logic        req;

    // Redirect source selection; a misaligned branch/jump target is replaced by the exception vector.
    always_comb begin
        redirect   = inException | inBranchTaken | inJump;
        raw_target = EXC_VECTOR;
        if (inException) begin
            raw_target = EXC_VECTOR;
        end else if (inBranchTaken) begin
            raw_target = inBranchTarget;
        end else if (inJump) begin
            raw_target = inJumpTarget;
        end
        misaligned  = !inException && (inBranchTaken || inJump) && (raw_target[1:0] != 2'b00);
        redirect_pc = misaligned ? EXC_VECTOR : raw_target;
    end

    // No new request is launched in a redirect cycle, so the address never changes under a pending request.
    always_comb begin
        slot_free = !instr_valid || !inStall;
        req       = 1'b0;
        case (state)
            ST_FETCH: req = slot_free && !redirect;
            ST_WAIT:  req = 1'b1;
            default:  req = 1'b0;
        endcase
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        req_addr_next    = req_addr;
        squash_next      = squash;
        instr_next       = instr;
        instr_pc_next    = instr_pc;
        instr_valid_next = inStall ? instr_valid : 1'b0;
        buf_data_next    = buf_data;
        buf_pc_next      = buf_pc;
        fetch_fault_next = 1'b0;
        fault_addr_next  = fault_addr;

        if (redirect) begin
            pc_next          = redirect_pc;
            instr_valid_next = 1'b0;
            if (misaligned) begin
                fetch_fault_next = 1'b1;
                fault_addr_next  = raw_target;
            end
            // A request already on the bus must complete; its data is dropped via squash.
            if (state == ST_WAIT && !inImemAck) begin
                squash_next = 1'b1;
            end else begin
                squash_next = 1'b0;
                state_next  = ST_FETCH;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_FETCH;
                end
                ST_FETCH: begin
                    if (req) begin
                        if (inImemAck) begin
                            instr_next       = inImemData;
                            instr_pc_next    = pc;
                            instr_valid_next = 1'b1;
                            pc_next          = inPCPlus4;
                        end else begin
                            req_addr_next = pc;
                            state_next    = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (inImemAck) begin
                        if (squash) begin
                            squash_next = 1'b0;
                            state_next  = ST_FETCH;
                        end else if (slot_free) begin
                            instr_next       = inImemData;
                            instr_pc_next    = pc;
                            instr_valid_next = 1'b1;
                            pc_next          = inPCPlus4;
                            state_next       = ST_FETCH;
                        end else begin
                            buf_data_next = inImemData;
                            buf_pc_next   = pc;
                            pc_next       = inPCPlus4;
                            state_next    = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!inStall) begin
                        instr_next       = buf_data;
                        instr_pc_next    = buf_pc;
                        instr_valid_next = 1'b1;
                        state_next       = ST_FETCH;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_VECTOR;
            req_addr    <= RESET_VECTOR;
            squash      <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
            buf_data    <= 32'h0;
            buf_pc      <= 32'h0;
            fetch_fault <= 1'b0;
            fault_addr  <= 32'h0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            req_addr    <= req_addr_next;
            squash      <= squash_next;
            instr       <= instr_next;
            instr_pc    <= instr_pc_next;
            instr_valid <= instr_valid_next;
            buf_data    <= buf_data_next;
            buf_pc      <= buf_pc_next;
            fetch_fault <= fetch_fault_next;
            fault_addr  <= fault_addr_next;
        end
    end

    assign outPC         = pc;
    assign outImemReq    = req;
    assign outImemAddr   = (state == ST_WAIT) ? req_addr : pc;
    assign outInstr      = instr;
    assign outInstrPC    = instr_pc;
    assign outInstrValid = instr_valid;
    assign outFetchFault = fetch_fault;
    assign outFaultAddr  = fault_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: random redirects, stalls, memory latency and resets; a monitor compares the
// delivered instruction stream against a program-order reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h0000_0180;
    localparam int          NUM_CYCLES   = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inPCPlus4;
    logic [31:0] outPC;
    logic        inException;
    logic        inBranchTaken;
    logic [31:0] inBranchTarget;
    logic        inJump;
    logic [31:0] inJumpTarget;
    logic        inStall;
    logic        outImemReq;
    logic [31:0] outImemAddr;
    logic        inImemAck;
    logic [31:0] inImemData;
    logic [31:0] outInstr;
    logic [31:0] outInstrPC;
    logic        outInstrValid;
    logic        outFetchFault;
    logic [31:0] outFaultAddr;

    always #5 clk = ~clk;

    assign inPCPlus4 = outPC + 32'd4;

    pc_fetch_unit #(
        .RESET_VECTOR(RESET_VECTOR),
        .EXC_VECTOR  (EXC_VECTOR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inPCPlus4     (inPCPlus4),
        .outPC         (outPC),
        .inException   (inException),
        .inBranchTaken (inBranchTaken),
        .inBranchTarget(inBranchTarget),
        .inJump        (inJump),
        .inJumpTarget  (inJumpTarget),
        .inStall       (inStall),
        .outImemReq    (outImemReq),
        .outImemAddr   (outImemAddr),
        .inImemAck     (inImemAck),
        .inImemData    (inImemData),
        .outInstr      (outInstr),
        .outInstrPC    (outInstrPC),
        .outInstrValid (outInstrValid),
        .outFetchFault (outFetchFault),
        .outFaultAddr  (outFaultAddr)
    );

    // One record per reset or redirect edge: where the program stream restarts and any fault expected.
    typedef struct {
        int unsigned edge_idx;
        bit          is_reset;
        logic [31:0] start_pc;
        bit          fault;
        logic [31:0] fault_addr;
    } event_t;

    event_t      ev_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          passed = 0;
    bit          done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] pickTarget();
        logic [31:0] t;
        t = 32'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF4;
        if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, actual, expected, cyc - 1);
        end
    endtask

    // Drives one edge's inputs per iteration and records what the reference model expects of it.
    task automatic applyStimulus();
        int     rst_hold  = 1;
        int     stall_run = 0;
        int     wait_cnt  = 0;
        bit     stray_ack = 1'b0;
        event_t ev;

        rst = 1'b1; inException = 1'b0; inBranchTaken = 1'b0; inJump = 1'b0;
        inBranchTarget = 32'h0; inJumpTarget = 32'h0; inStall = 1'b0;
        inImemAck = 1'b0; inImemData = 32'h0;
        ev = '{edge_idx: 0, is_reset: 1'b1, start_pc: RESET_VECTOR, fault: 1'b0, fault_addr: 32'h0};
        ev_q.push_back(ev);

        for (int i = 0; i < NUM_CYCLES; i++) begin
            @(negedge clk);
            #1;
            rst = 1'b0; inException = 1'b0; inBranchTaken = 1'b0; inJump = 1'b0;
            inImemAck = 1'b0; inImemData = 32'h0;
            inBranchTarget = pickTarget();
            inJumpTarget   = pickTarget();

            if (stall_run >= 3) inStall = 1'b0;
            else inStall = ($urandom_range(0, 99) < 30);
            stall_run = inStall ? stall_run + 1 : 0;

            if (rst_hold > 0) begin
                rst = 1'b1;
                rst_hold--;
            end else if (cyc > 20 && $urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                rst_hold = int'($urandom_range(0, 1));
            end

            if (rst) begin
                ev = '{edge_idx: cyc, is_reset: 1'b1, start_pc: RESET_VECTOR, fault: 1'b0, fault_addr: 32'h0};
                ev_q.push_back(ev);
                wait_cnt  = 0;
                stray_ack = (rst_hold == 0);
                continue;
            end

            // A late acknowledge arriving after reset, with no request outstanding, must be ignored.
            if (stray_ack) begin
                stray_ack  = 1'b0;
                inImemAck  = 1'b1;
                inImemData = 32'hDEAD_BEEF;
                continue;
            end

            if ($urandom_range(0, 99) < 8) begin
                logic [31:0] tgt;
                inException   = ($urandom_range(0, 3) == 0);
                inBranchTaken = 1'($urandom_range(0, 1));
                inJump        = 1'($urandom_range(0, 1));
                if (!inException && !inBranchTaken && !inJump) inJump = 1'b1;
                ev = '{edge_idx: cyc, is_reset: 1'b0, start_pc: EXC_VECTOR, fault: 1'b0, fault_addr: 32'h0};
                if (!inException) begin
                    tgt = inBranchTaken ? inBranchTarget : inJumpTarget;
                    if (tgt % 4 != 0) begin
                        ev.fault      = 1'b1;
                        ev.fault_addr = tgt;
                    end else begin
                        ev.start_pc = tgt;
                    end
                end
                ev_q.push_back(ev);
            end

            #1;
            if (outImemReq) begin
                wait_cnt++;
                if (wait_cnt >= 4 || $urandom_range(0, 99) < 45) begin
                    inImemAck  = 1'b1;
                    inImemData = memWord(outImemAddr);
                    wait_cnt   = 0;
                end
            end
        end

        @(negedge clk);
        #1;
        rst = 1'b0; inException = 1'b0; inBranchTaken = 1'b0; inJump = 1'b0;
        inStall = 1'b0; inImemAck = 1'b0;
        @(negedge clk);
        #1;
        done = 1'b1;
    endtask

    // Compares each consumed instruction with the next one in program order, and checks redirect/fault effects.
    task automatic monitorLoop();
        logic [31:0] exp_pc = RESET_VECTOR;
        bit          snap_v = 1'b0;
        logic [31:0] snap_instr = 32'h0;
        logic [31:0] snap_pc = 32'h0;
        int          stuck = 0;
        int unsigned e;
        bit          have_ev;
        event_t      ev;

        while (!done) begin
            @(negedge clk);
            e = cyc - 1;
            have_ev = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].edge_idx == e) begin
                ev = ev_q.pop_front();
                have_ev = 1'b1;
            end

            if (have_ev && ev.is_reset) begin
                checkOutput("reset_pc", outPC, RESET_VECTOR);
                checkOutput("reset_req", {31'b0, outImemReq}, 32'd0);
                checkOutput("reset_valid", {31'b0, outInstrValid}, 32'd0);
                checkOutput("reset_instr", outInstr, 32'd0);
                checkOutput("reset_instr_pc", outInstrPC, 32'd0);
                checkOutput("reset_fault", {31'b0, outFetchFault}, 32'd0);
                checkOutput("reset_fault_addr", outFaultAddr, 32'd0);
                exp_pc = RESET_VECTOR;
                stuck  = 0;
            end else begin
                if (snap_v && !inStall && !have_ev) begin
                    checkOutput("instr_pc", snap_pc, exp_pc);
                    checkOutput("instr_word", snap_instr, memWord(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    stuck  = 0;
                end else begin
                    stuck++;
                end
                if (have_ev) begin
                    exp_pc = ev.start_pc;
                    stuck  = 0;
                    checkOutput("redirect_pc", outPC, ev.start_pc);
                    checkOutput("redirect_valid", {31'b0, outInstrValid}, 32'd0);
                    if (ev.fault) checkOutput("fault_addr", outFaultAddr, ev.fault_addr);
                end
                checkOutput("fault_pulse", {31'b0, outFetchFault}, {31'b0, have_ev && ev.fault});
                checkOutput("progress", {31'b0, stuck > 30}, 32'd0);
                if (stuck > 30) stuck = 0;
            end

            snap_v     = outInstrValid;
            snap_instr = outInstr;
            snap_pc    = outInstrPC;
        end
    endtask

    initial begin
        fork
            applyStimulus();
            monitorLoop();
        join
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #((NUM_CYCLES + 200) * 10);
        $display("[TB] FAIL watchdog: still running at %0t, expected completion before %0d cycles", $time, NUM_CYCLES + 200);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
